run_controller: RTL and testbench
=================================

Name: run_controller

Overview:
- Parametrised program-run sequencer for the 9-bit-instruction core. Supersedes the ad-hoc start/done/instruction-count logic in the core top level.
- Holds a table of program entry addresses and selects one per run. Loads the fetch unit's PC, gates core execution, and counts retired instructions and cycles.
- Ends a run on the decoder's halt or on a watchdog timeout, and reports the cause.

Parameters:
NUM_PROGS, 4, number of program entry points in the table (>=1)
ADDR_W, 10, width of instruction-ROM start address
CNT_W, 16, width of instr_count and cycle_count
TIMEOUT, 0, watchdog limit in RUN cycles; 0 disables the watchdog

Ports:
clk  input  1  system clock, all logic on posedge
rst_n  input  1  synchronous active-low reset
start  input  1  run request, sampled in IDLE/DONE only
prog_sel  input  max(1,$clog2(NUM_PROGS))  entry-table index used at start
entry_we  input  1  entry-table write enable
entry_idx  input  max(1,$clog2(NUM_PROGS))  entry-table write index
entry_addr  input  ADDR_W  entry-table write data
halt_in  input  1  decoder done/halt indication for current instruction
stall  input  1  core stalled this cycle (instruction not retired)
start_addr  output  ADDR_W  PC load value for the fetch unit
core_load  output  1  one-cycle PC-load strobe to the fetch unit
run  output  1  core execute enable
done  output  1  run finished (halt or timeout)
timeout_err  output  1  last run ended by the watchdog
instr_count  output  CNT_W  instructions retired in current/last run
cycle_count  output  CNT_W  RUN cycles in current/last run

Behaviour:
- Reset (rst_n=0 at posedge): state=IDLE. start_addr=0, core_load=0, run=0, done=0, timeout_err=0, both counts=0, all table entries=0. Reset in any state, including mid-RUN, aborts the run.
- FSM has states IDLE, LOAD, RUN and DONE. All outputs are registered or decoded from the registered state.
- IDLE/DONE with start=1:
  - Next state is LOAD.
  - start_addr <= table[prog_sel]. An out-of-range prog_sel (NUM_PROGS not a power of 2) selects entry 0.
  - Both counts and timeout_err clear to 0.
- DONE with start=0: hold. done=1, run=0, counts and timeout_err frozen.
- LOAD: core_load=1 for exactly one cycle, run=0, next state RUN.
- RUN, every cycle:
  - run=1.
  - cycle_count increments, saturating at all-ones.
  - If stall=0, instr_count increments, saturating at all-ones.
  - start is ignored in RUN; only rst_n aborts a run.
- RUN exit on halt: halt_in=1 with stall=0 means next state DONE. The halting instruction is counted. halt_in while stall=1 is ignored.
- RUN exit on timeout: TIMEOUT!=0 and cycle_count==TIMEOUT-1 at the edge means next state DONE with timeout_err<=1, so RUN lasts exactly TIMEOUT cycles.
- Halt and timeout on the same edge: halt wins and timeout_err stays 0.
- done=1 exactly while state==DONE, first visible the cycle after the exiting edge.
- Entry table:
  - Writes are accepted only in IDLE or DONE and are ignored in LOAD/RUN.
  - If entry_we and start occur on the same edge, start reads the pre-write value (read-before-write).
- Latency from start to the first executed instruction: start sampled at edge N, core_load high in cycle N+1, run high from cycle N+2.

Test Plan:
- Reset then idle: rst_n=0 for 2 cycles, release -> all outputs 0, state IDLE, and start_addr=0 after 10 idle cycles.
- Table plus basic run: write entry 2=0x040, start with prog_sel=2 -> start_addr=0x040, core_load high for 1 cycle, run from N+2. Then halt_in after 5 unstalled RUN cycles -> done=1, instr_count=5, cycle_count=5, timeout_err=0.
- Stalls: 8 RUN cycles with stall=1 on 3 of them, halt_in on the 8th (stall=0) -> instr_count=5, cycle_count=8. A halt_in asserted during a stall cycle does not end the run.
- Watchdog: TIMEOUT=20, no halt -> done after exactly 20 RUN cycles, timeout_err=1, cycle_count=20. Halt on the 20th cycle instead -> timeout_err=0.
- Restart and protection: start in DONE with prog_sel=1 -> counts cleared, new start_addr. start and entry_we pulsed in RUN -> ignored. Same-edge write and start on the same index in IDLE -> old address used.
- Saturation and abort: CNT_W=4, 20 unstalled cycles -> both counts hold at 15. rst_n=0 mid-RUN -> IDLE, run=0, counts=0 next cycle.

Source files
------------

// File: rtl/run_controller_if.sv
// Control and status bundle between the run controller and its host/core.
// The host drives requests and core status; the controller drives PC load and run status.
interface run_controller_if #(
  parameter int NUM_PROGS = 4,
  parameter int ADDR_W    = 10,
  parameter int CNT_W     = 16
);
  localparam int SEL_W = (NUM_PROGS > 1) ? $clog2(NUM_PROGS) : 1;

  logic              start;
  logic [SEL_W-1:0]  prog_sel;
  logic              entry_we;
  logic [SEL_W-1:0]  entry_idx;
  logic [ADDR_W-1:0] entry_addr;
  logic              halt_in;
  logic              stall;
  logic [ADDR_W-1:0] start_addr;
  logic              core_load;
  logic              run;
  logic              done;
  logic              timeout_err;
  logic [CNT_W-1:0]  instr_count;
  logic [CNT_W-1:0]  cycle_count;

  modport master (
    output start, prog_sel, entry_we, entry_idx, entry_addr, halt_in, stall,
    input  start_addr, core_load, run, done, timeout_err, instr_count, cycle_count
  );

  modport slave (
    input  start, prog_sel, entry_we, entry_idx, entry_addr, halt_in, stall,
    output start_addr, core_load, run, done, timeout_err, instr_count, cycle_count
  );
endinterface

// File: rtl/run_controller.sv
// Program-run sequencer: picks an entry address, loads the PC, gates execution,
// counts retired instructions and RUN cycles, and ends on halt or watchdog timeout.
//
// state  | meaning
// IDLE   | no run since reset; table writable, waiting for start
// LOAD   | one-cycle PC load strobe to the fetch unit
// RUN    | core executing; counters advance, halt/watchdog checked
// DONE   | run finished; results frozen, table writable, restart allowed
module run_controller #(
  parameter int NUM_PROGS = 4,
  parameter int ADDR_W    = 10,
  parameter int CNT_W     = 16,
  parameter int TIMEOUT   = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  run_controller_if.slave bus
);
  localparam int SEL_W = (NUM_PROGS > 1) ? $clog2(NUM_PROGS) : 1;
  localparam logic [CNT_W-1:0] WD_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_DONE} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] start_addr_q, start_addr_d;
  logic [CNT_W-1:0]  instr_count_q, instr_count_d;
  logic [CNT_W-1:0]  cycle_count_q, cycle_count_d;
  logic              timeout_err_q, timeout_err_d;
  logic [ADDR_W-1:0] table_q [NUM_PROGS];
  logic [ADDR_W-1:0] table_d [NUM_PROGS];
  logic [ADDR_W-1:0] sel_addr;
  logic              halt_ok;
  logic              wd_hit;

  // Out-of-range selections fall back to entry 0.
  always_comb begin
    sel_addr = table_q[0];
    for (int i = 0; i < NUM_PROGS; i++) begin
      if (bus.prog_sel == SEL_W'(i)) sel_addr = table_q[i];
    end
  end

  always_comb begin
    state_d       = state_q;
    start_addr_d  = start_addr_q;
    instr_count_d = instr_count_q;
    cycle_count_d = cycle_count_q;
    timeout_err_d = timeout_err_q;
    table_d       = table_q;
    halt_ok       = bus.halt_in && !bus.stall;
    wd_hit        = (TIMEOUT != 0) && (cycle_count_q == WD_LAST);

    case (state_q)
      S_IDLE, S_DONE: begin
        // start samples table_q, so a same-edge write is seen only by later runs.
        if (bus.entry_we) begin
          for (int i = 0; i < NUM_PROGS; i++) begin
            if (bus.entry_idx == SEL_W'(i)) table_d[i] = bus.entry_addr;
          end
        end
        if (bus.start) begin
          state_d       = S_LOAD;
          start_addr_d  = sel_addr;
          instr_count_d = '0;
          cycle_count_d = '0;
          timeout_err_d = 1'b0;
        end
      end
      S_LOAD: state_d = S_RUN;
      S_RUN: begin
        if (cycle_count_q != '1) cycle_count_d = cycle_count_q + 1'b1;
        if (!bus.stall && instr_count_q != '1) instr_count_d = instr_count_q + 1'b1;
        if (halt_ok) begin
          state_d = S_DONE;
        end else if (wd_hit) begin
          state_d       = S_DONE;
          timeout_err_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      start_addr_q  <= '0;
      instr_count_q <= '0;
      cycle_count_q <= '0;
      timeout_err_q <= 1'b0;
      for (int i = 0; i < NUM_PROGS; i++) table_q[i] <= '0;
    end else begin
      state_q       <= state_d;
      start_addr_q  <= start_addr_d;
      instr_count_q <= instr_count_d;
      cycle_count_q <= cycle_count_d;
      timeout_err_q <= timeout_err_d;
      table_q       <= table_d;
    end
  end

  assign bus.start_addr  = start_addr_q;
  assign bus.core_load   = (state_q == S_LOAD);
  assign bus.run         = (state_q == S_RUN);
  assign bus.done        = (state_q == S_DONE);
  assign bus.timeout_err = timeout_err_q;
  assign bus.instr_count = instr_count_q;
  assign bus.cycle_count = cycle_count_q;
endmodule

// File: tb/tb_run_controller.sv
// Bench for run_controller: three configurations (plain, watchdog=20, 3 entries with 4-bit counts)
// share one stimulus stream and are checked every cycle against a behavioural model.
module tb_run_controller;
  logic       clk;
  logic       rst_n;
  logic       start;
  logic [1:0] prog_sel;
  logic       entry_we;
  logic [1:0] entry_idx;
  logic [9:0] entry_addr;
  logic       halt_in;
  logic       stall;

  logic [2:0] o_load, o_run, o_done, o_to;
  logic [9:0]  o_addr [3];
  logic [15:0] o_ic   [3];
  logic [15:0] o_cc   [3];

  int checks = 0;
  int errors = 0;

  function automatic int np(int g);   return (g == 2) ? 3 : 4;      endfunction
  function automatic int cmax(int g); return (g == 2) ? 15 : 65535; endfunction
  function automatic int tm(int g);   return (g == 1) ? 20 : 0;     endfunction

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int GNP = (g == 2) ? 3 : 4;
    localparam int GCW = (g == 2) ? 4 : 16;
    localparam int GTM = (g == 1) ? 20 : 0;
    run_controller_if #(.NUM_PROGS(GNP), .ADDR_W(10), .CNT_W(GCW)) bus ();
    run_controller #(.NUM_PROGS(GNP), .ADDR_W(10), .CNT_W(GCW), .TIMEOUT(GTM)) dut (
      .clk(clk), .rst_n(rst_n), .bus(bus)
    );
    assign bus.start      = start;
    assign bus.prog_sel   = prog_sel;
    assign bus.entry_we   = entry_we;
    assign bus.entry_idx  = entry_idx;
    assign bus.entry_addr = entry_addr;
    assign bus.halt_in    = halt_in;
    assign bus.stall      = stall;
    assign o_load[g] = bus.core_load;
    assign o_run[g]  = bus.run;
    assign o_done[g] = bus.done;
    assign o_to[g]   = bus.timeout_err;
    assign o_addr[g] = bus.start_addr;
    assign o_ic[g]   = 16'(bus.instr_count);
    assign o_cc[g]   = 16'(bus.cycle_count);
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: phase 0 idle, 1 load, 2 run, 3 done.
  int m_ph [3];
  int m_addr [3];
  int m_ic [3];
  int m_cc [3];
  int m_to [3];
  int m_tab [3][4];

  always @(posedge clk) begin
    int s, prev;
    for (int g = 0; g < 3; g++) begin
      if (!rst_n) begin
        m_ph[g] = 0; m_addr[g] = 0; m_ic[g] = 0; m_cc[g] = 0; m_to[g] = 0;
        for (int k = 0; k < 4; k++) m_tab[g][k] = 0;
      end else if (m_ph[g] == 0 || m_ph[g] == 3) begin
        s = (int'(prog_sel) < np(g)) ? int'(prog_sel) : 0;
        if (start) begin
          m_addr[g] = m_tab[g][s];
          m_ic[g] = 0; m_cc[g] = 0; m_to[g] = 0; m_ph[g] = 1;
        end
        if (entry_we && int'(entry_idx) < np(g)) m_tab[g][entry_idx] = int'(entry_addr);
      end else if (m_ph[g] == 1) begin
        m_ph[g] = 2;
      end else begin
        prev = m_cc[g];
        if (m_cc[g] < cmax(g)) m_cc[g]++;
        if (!stall && m_ic[g] < cmax(g)) m_ic[g]++;
        if (halt_in && !stall) m_ph[g] = 3;
        else if (tm(g) != 0 && prev == tm(g) - 1) begin
          m_ph[g] = 3; m_to[g] = 1;
        end
      end
    end
  end

  task automatic cyc();
    logic [45:0] exp_v, act_v;
    @(posedge clk);
    #1;
    for (int g = 0; g < 3; g++) begin
      exp_v = {m_ph[g] == 1, m_ph[g] == 2, m_ph[g] == 3, m_to[g] != 0,
               10'(m_addr[g]), 16'(m_ic[g]), 16'(m_cc[g])};
      act_v = {o_load[g], o_run[g], o_done[g], o_to[g], o_addr[g], o_ic[g], o_cc[g]};
      checks++;
      if (act_v !== exp_v) begin
        errors++;
        $display("FAIL model_dut%0d t=%0t actual=%h required=%h", g, $time, act_v, exp_v);
      end
    end
  endtask

  task automatic chk(string nm, int act, int exp_v);
    checks++;
    if (act != exp_v) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, exp_v);
    end
  endtask

  task automatic start_run(int sel);
    start = 1'b1; prog_sel = 2'(sel);
    cyc();
    start = 1'b0;
  endtask

  task automatic run_cycles(int n);
    for (int k = 0; k < n; k++) cyc();
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; prog_sel = '0; entry_we = 1'b0;
    entry_idx = '0; entry_addr = '0; halt_in = 1'b0; stall = 1'b0;

    run_cycles(2);
    chk("rst_run", int'(o_run[0]), 0);
    chk("rst_done", int'(o_done[0]), 0);
    chk("rst_ic", int'(o_ic[0]), 0);
    rst_n = 1'b1;
    run_cycles(10);
    chk("idle_addr", int'(o_addr[0]), 0);
    chk("idle_load", int'(o_load), 0);

    entry_we = 1'b1; entry_idx = 2'd2; entry_addr = 10'h040;
    cyc();
    entry_we = 1'b0;
    start_run(2);
    chk("basic_load", int'(o_load[0]), 1);
    chk("basic_addr", int'(o_addr[0]), 'h040);
    chk("basic_run_n1", int'(o_run[0]), 0);
    cyc();
    chk("basic_run_n2", int'(o_run[0]), 1);
    chk("basic_load_off", int'(o_load[0]), 0);
    run_cycles(4);
    halt_in = 1'b1;
    cyc();
    halt_in = 1'b0;
    chk("basic_done", int'(o_done[0]), 1);
    chk("basic_ic", int'(o_ic[0]), 5);
    chk("basic_cc", int'(o_cc[0]), 5);
    chk("basic_to", int'(o_to[0]), 0);

    start_run(2);
    cyc();
    for (int k = 1; k <= 8; k++) begin
      stall   = (k == 2 || k == 4 || k == 6);
      halt_in = (k == 4 || k == 8);
      cyc();
      if (k == 4) chk("stall_halt_ignored", int'(o_run[0]), 1);
    end
    stall = 1'b0; halt_in = 1'b0;
    chk("stall_done", int'(o_done[0]), 1);
    chk("stall_ic", int'(o_ic[0]), 5);
    chk("stall_cc", int'(o_cc[0]), 8);

    start_run(0);
    cyc();
    run_cycles(24);
    chk("wd_done", int'(o_done[1]), 1);
    chk("wd_to", int'(o_to[1]), 1);
    chk("wd_cc", int'(o_cc[1]), 20);
    chk("sat_cc", int'(o_cc[2]), 15);
    chk("sat_ic", int'(o_ic[2]), 15);
    chk("nowd_run", int'(o_run[0]), 1);
    halt_in = 1'b1;
    cyc();
    halt_in = 1'b0;
    chk("nowd_cc", int'(o_cc[0]), 25);

    entry_we = 1'b1; entry_idx = 2'd1; entry_addr = 10'h123;
    cyc();
    entry_we = 1'b0;
    start_run(1);
    chk("restart_addr", int'(o_addr[0]), 'h123);
    chk("restart_to_clr", int'(o_to[1]), 0);
    chk("restart_cc_clr", int'(o_cc[1]), 0);
    cyc();
    for (int k = 1; k <= 19; k++) begin
      if (k == 5) begin
        start = 1'b1; prog_sel = 2'd2;
        entry_we = 1'b1; entry_idx = 2'd1; entry_addr = 10'h3FF;
      end
      cyc();
      start = 1'b0; entry_we = 1'b0;
    end
    halt_in = 1'b1;
    cyc();
    halt_in = 1'b0;
    chk("halt20_done", int'(o_done[1]), 1);
    chk("halt20_to", int'(o_to[1]), 0);
    chk("halt20_cc", int'(o_cc[1]), 20);
    start_run(1);
    chk("protect_addr", int'(o_addr[0]), 'h123);
    cyc();
    halt_in = 1'b1;
    cyc();
    halt_in = 1'b0;

    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    entry_we = 1'b1; entry_idx = 2'd3; entry_addr = 10'h155;
    cyc();
    entry_addr = 10'h2AA;
    start_run(3);
    entry_we = 1'b0;
    chk("rbw_addr", int'(o_addr[0]), 'h155);
    chk("oor_sel_addr", int'(o_addr[2]), 0);
    cyc();
    halt_in = 1'b1;
    cyc();
    halt_in = 1'b0;
    start_run(3);
    chk("rbw_new_addr", int'(o_addr[0]), 'h2AA);
    cyc();
    run_cycles(3);
    chk("abort_pre_cc", int'(o_cc[0]), 3);
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    chk("abort_run", int'(o_run[0]), 0);
    chk("abort_cc", int'(o_cc[0]), 0);
    chk("abort_ic", int'(o_ic[0]), 0);

    for (int n = 0; n < 3000; n++) begin
      rst_n      = ($urandom_range(0, 199) != 0);
      start      = ($urandom_range(0, 7) == 0);
      prog_sel   = 2'($urandom_range(0, 3));
      entry_we   = ($urandom_range(0, 3) == 0);
      entry_idx  = 2'($urandom_range(0, 3));
      entry_addr = 10'($urandom_range(0, 1023));
      halt_in    = ($urandom_range(0, 9) == 0);
      stall      = ($urandom_range(0, 2) == 0);
      cyc();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
